// File: rtl/digit_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
`timescale 1ns/1ps
package digit_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Pick digit 'idx' out of the packed 16-bit digit word.
    function automatic logic [3:0] select_nibble(input logic [15:0] word,
                                                 input logic [IDX_W-1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_slot_timer.sv
// Slot cycle counter: counts 0..DIV-1 and flags the end of the blanking
// window and the end of the slot.
`timescale 1ns/1ps
module slot_timer #(
    parameter int DIV   = 1000,
    parameter int BLANK = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign blank_done_o = (cnt_q == BLANK_LAST);
    assign slot_done_o  = (cnt_q == SLOT_LAST);

    // Next count: clear wins, otherwise wrap at the slot end so cnt stays <= DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (slot_done_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scan controller feeding a 2-to-4 decoder, with a
// blanking window at the start of every slot to hide select changes.
`timescale 1ns/1ps
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] digits,
    output logic        sel_i0,
    output logic        sel_i1,
    output logic        blank,
    output logic [3:0]  nibble,
    output logic        frame_start
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             blank_q, blank_d;
    logic [3:0]       nibble_q, nibble_d;
    logic             frame_start_q, frame_start_d;
    logic             clear_s;
    logic             blank_done_s;
    logic             slot_done_s;

    slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear_s),
        .blank_done_o (blank_done_s),
        .slot_done_o  (slot_done_s)
    );

    // Next-state and next-output logic; dropping en from any scanning state returns to IDLE.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        blank_d       = blank_q;
        nibble_d      = nibble_q;
        frame_start_d = 1'b0;
        clear_s       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                blank_d = 1'b1;
                if (en) begin
                    state_d       = ST_BLANK;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    blank_d = 1'b1;
                end else begin
                    clear_s = 1'b0;
                    blank_d = 1'b1;
                    if (blank_done_s) begin
                        state_d  = ST_SHOW;
                        blank_d  = 1'b0;
                        nibble_d = select_nibble(digits, idx_q);
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    blank_d = 1'b1;
                end else begin
                    clear_s = 1'b0;
                    blank_d = 1'b0;
                    if (slot_done_s) begin
                        // Select only moves here, together with blank rising.
                        state_d       = ST_BLANK;
                        blank_d       = 1'b1;
                        idx_d         = idx_q + IDX_W'(1);
                        frame_start_d = (idx_q == LAST_IDX);
                    end else begin
                        state_d = ST_SHOW;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                blank_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            blank_q       <= 1'b1;
            nibble_q      <= 4'd0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            blank_q       <= blank_d;
            nibble_q      <= nibble_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sel_i0      = idx_q[0];
    assign sel_i1      = idx_q[1];
    assign blank       = blank_q;
    assign nibble      = nibble_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: directed scenarios plus a random
// phase, all compared against a time-since-frame-start reference model.
`timescale 1ns/1ps
module tb_digit_scan_ctrl;

    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits;
    logic        sel_i0, sel_i1, blank, frame_start;
    logic [3:0]  nibble;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: position within the frame, derived from elapsed cycles.
    bit         m_scan;
    int         m_t;
    logic       m_blank, m_fs;
    logic [1:0] m_sel;
    logic [3:0] m_nib;
    logic [1:0] prev_sel;

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    digit_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .digits      (digits),
        .sel_i0      (sel_i0),
        .sel_i1      (sel_i1),
        .blank       (blank),
        .nibble      (nibble),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_scan  = 1'b0;
        m_t     = 0;
        m_blank = 1'b1;
        m_fs    = 1'b0;
        m_sel   = 2'd0;
        m_nib   = 4'd0;
    endtask

    task automatic check_all();
        chk("blank",       16'(blank),            16'(m_blank));
        chk("sel",         16'({sel_i1, sel_i0}), 16'(m_sel));
        chk("nibble",      16'(nibble),           16'(m_nib));
        chk("frame_start", 16'(frame_start),      16'(m_fs));
        if ({sel_i1, sel_i0} !== prev_sel)
            chk("sel_change_blank", 16'(blank), 16'd1);
        prev_sel = {sel_i1, sel_i0};
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic step();
        int pos, slot;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_reset();
        end else if (!m_scan) begin
            m_blank = 1'b1;
            m_sel   = 2'd0;
            m_fs    = 1'b0;
            if (en) begin
                m_scan = 1'b1;
                m_t    = 0;
                m_fs   = 1'b1;
            end
        end else if (!en) begin
            m_scan  = 1'b0;
            m_t     = 0;
            m_blank = 1'b1;
            m_sel   = 2'd0;
            m_fs    = 1'b0;
        end else begin
            m_t     = (m_t + 1) % FRAME;
            pos     = m_t % DIV;
            slot    = m_t / DIV;
            m_blank = (pos < BLANK);
            m_sel   = 2'(slot);
            m_fs    = (m_t == 0);
            if (pos == BLANK) m_nib = digits[4*slot +: 4];
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until(input int target);
        int k;
        k = 0;
        while ((m_t != target) && (k < 100)) begin
            step();
            k++;
        end
        chk("reach_position", 16'(m_t), 16'(target));
    endtask

    initial begin
        int nb;
        int fs_first, fs_second;

        rst    = 1'b1;
        en     = 1'b0;
        digits = 16'h4321;
        model_reset();
        prev_sel = 2'd0;
        repeat (2) @(negedge clk);
        chk("rst_blank",  16'(blank),            16'd1);
        chk("rst_sel",    16'({sel_i1, sel_i0}), 16'd0);
        chk("rst_nibble", 16'(nibble),           16'd0);
        chk("rst_fs",     16'(frame_start),      16'd0);
        rst = 1'b0;
        repeat (3) step();

        // Start scanning and watch one complete frame.
        en = 1'b1;
        step();
        chk("first_fs", 16'(frame_start), 16'd1);
        fs_first  = cyc;
        fs_second = -1;
        nb = 0;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (blank === 1'b1) nb++;
            if ((frame_start === 1'b1) && (fs_second < 0)) fs_second = cyc;
            if (i == BLANK) begin
                chk("first_show_blank",  16'(blank),            16'd0);
                chk("first_show_nibble", 16'(nibble),           16'd1);
                chk("first_show_sel",    16'({sel_i1, sel_i0}), 16'd0);
            end
            if (i == DIV) chk("second_slot_sel", 16'({sel_i1, sel_i0}), 16'd1);
        end
        chk("blank_duty",     16'(nb),                     16'(4 * BLANK));
        chk("frame_interval", 16'(fs_second - fs_first),   16'(FRAME));

        // Digits change in the middle of slot 1's SHOW phase.
        run_until(DIV + 5);
        digits = 16'hFFFF;
        run_until(2 * DIV + BLANK - 1);
        chk("no_tearing", 16'(nibble), 16'h2);
        step();
        chk("slot2_latch", 16'(nibble), 16'hF);

        // One-cycle enable drop during slot 2.
        run_until(2 * DIV + 5);
        en = 1'b0;
        step();
        chk("drop_blank", 16'(blank),            16'd1);
        chk("drop_sel",   16'({sel_i1, sel_i0}), 16'd0);
        en = 1'b1;
        step();
        chk("restart_fs", 16'(frame_start), 16'd1);

        // Asynchronous reset in the middle of slot 3's SHOW phase.
        run_until(3 * DIV + 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_blank",  16'(blank),            16'd1);
        chk("async_sel",    16'({sel_i1, sel_i0}), 16'd0);
        chk("async_nibble", 16'(nibble),           16'd0);
        chk("async_fs",     16'(frame_start),      16'd0);
        model_reset();
        prev_sel = 2'd0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("resume_fs", 16'(frame_start), 16'd1);

        // Random enable drops and digit changes.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 5) == 0) digits = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
